// File: rtl/matmul2x2_seq.sv
// matmul2x2_seq: sequences four dot-product ALU operations to form C = A x B
// for 2x2 unsigned 8-bit matrices, collecting 18-bit results into c_mat.
module matmul2x2_seq #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] a_mat,
   input  logic [31:0] b_mat,
   output logic [7:0]  alu_row0,
   output logic [7:0]  alu_row1,
   output logic [7:0]  alu_col0,
   output logic [7:0]  alu_col1,
   output logic        alu_start,
   input  logic [17:0] alu_out,
   input  logic        alu_complete,
   output logic [71:0] c_mat,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned DW = 8;
   localparam int unsigned RW = 18;
   localparam int unsigned MW = 4 * DW;
   localparam int unsigned CW = 8;
   localparam int unsigned XW = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic [MW-1:0]   a_q;
   logic [MW-1:0]   b_q;
   logic [XW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;

   // Next wait-count value, compared against TIMEOUT to detect the abort cycle
   always_comb begin
      cnt_nxt = cnt + CW'(1);
   end

   // Operand select: idx[1] picks the A row, idx[0] picks the B column
   always_comb begin
      alu_row0 = idx[1] ? a_q[23:16] : a_q[7:0];
      alu_row1 = idx[1] ? a_q[31:24] : a_q[15:8];
      alu_col0 = idx[0] ? b_q[15:8]  : b_q[7:0];
      alu_col1 = idx[0] ? b_q[31:24] : b_q[23:16];
   end

   // Job sequencer: latch operands, issue one ALU op per element, collect results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx       <= '0;
         cnt       <= '0;
         c_mat     <= '0;
         alu_start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  a_q       <= a_mat;
                  b_q       <= b_mat;
                  idx       <= '0;
                  err       <= 1'b0;
                  alu_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (alu_complete) begin
                  c_mat[RW*32'(idx) +: RW] <= alu_out;
                  if (idx == XW'(3)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     idx       <= idx + XW'(1);
                     alu_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end else if (32'(cnt_nxt) == TIMEOUT) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul2x2_seq.sv
// tb_matmul2x2_seq: directed bench for matmul2x2_seq with a 3-edge-latency ALU stub.
module tb_matmul2x2_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [31:0] a_mat = '0;
   logic [31:0] b_mat = '0;
   logic [7:0]  alu_row0, alu_row1, alu_col0, alu_col1;
   logic        alu_start;
   logic [17:0] alu_out;
   logic        alu_complete;
   logic [71:0] c_mat;
   logic        busy, done, err;

   int n_chk = 0;
   int n_fail = 0;

   // ALU stub state
   logic        alu_en = 1'b1;
   logic        spur = 1'b0;
   logic [17:0] m_res = '0;
   logic [17:0] m_out = '0;
   logic        m_pend = 1'b0;
   logic        m_cnt = 1'b0;
   logic        m_cmp = 1'b0;

   logic [31:0] ops;
   logic [31:0] ops_seen [4];

   matmul2x2_seq #(.TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .a_mat(a_mat), .b_mat(b_mat),
      .alu_row0(alu_row0), .alu_row1(alu_row1), .alu_col0(alu_col0), .alu_col1(alu_col1),
      .alu_start(alu_start), .alu_out(alu_out), .alu_complete(alu_complete),
      .c_mat(c_mat), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   assign ops          = {alu_col1, alu_col0, alu_row1, alu_row0};
   assign alu_complete = m_cmp | spur;
   assign alu_out      = spur ? 18'h3FFFF : m_out;

   // Dot-product ALU stub: complete is sampled by the DUT 3 edges after start
   always @(posedge clk) begin
      m_cmp <= 1'b0;
      if (!rst_n) begin
         m_pend <= 1'b0;
      end else if (alu_start && alu_en) begin
         m_res  <= 18'(alu_row0) * 18'(alu_col0) + 18'(alu_row1) * 18'(alu_col1);
         m_pend <= 1'b1;
         m_cnt  <= 1'b1;
      end else if (m_pend) begin
         if (m_cnt == 1'b0) begin
            m_cmp  <= 1'b1;
            m_out  <= m_res;
            m_pend <= 1'b0;
         end else begin
            m_cnt <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] cpack(input int c00, input int c01, input int c10, input int c11);
      return {18'(c11), 18'(c10), 18'(c01), 18'(c00)};
   endfunction

   // Walks cycles until done is seen (bounded), tallying busy/start samples
   task automatic wait_done(input int t0, output int lat, output int nbusy, output int nstart);
      lat = t0;
      nbusy = 0;
      nstart = 0;
      while (lat < 60) begin
         if (alu_start) begin
            if (nstart < 4) ops_seen[nstart] = ops;
            nstart++;
         end
         if (busy) nbusy++;
         if (done) break;
         tick();
         lat++;
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      a_mat = a;
      b_mat = b;
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   initial begin
      int lat, nb, ns;
      logic seen;

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_flags", 72'({busy, done, err, alu_start}), 72'(0));
      chk("rst_cmat", c_mat, 72'(0));
      chk("rst_ops", 72'(ops), 72'(0));
      rst_n = 1'b1;
      tick();

      // Job 1: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
      launch(32'h04030201, 32'h08070605);
      wait_done(0, lat, nb, ns);
      chk("j1_latency", 72'(lat), 72'(16));
      chk("j1_busy_cycles", 72'(nb), 72'(16));
      chk("j1_starts", 72'(ns), 72'(4));
      chk("j1_ops0", 72'(ops_seen[0]), 72'(32'h07050201));
      chk("j1_ops1", 72'(ops_seen[1]), 72'(32'h08060201));
      chk("j1_ops2", 72'(ops_seen[2]), 72'(32'h07050403));
      chk("j1_ops3", 72'(ops_seen[3]), 72'(32'h08060403));
      chk("j1_cmat", c_mat, cpack(19, 22, 43, 50));
      chk("j1_err", 72'(err), 72'(0));
      tick();
      chk("j1_done_single", 72'(done), 72'(0));

      // Job 2: all operands 0xFF
      launch(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(0, lat, nb, ns);
      chk("ff_latency", 72'(lat), 72'(16));
      chk("ff_ops0", 72'(ops_seen[0]), 72'(32'hFFFFFFFF));
      chk("ff_ops3", 72'(ops_seen[3]), 72'(32'hFFFFFFFF));
      chk("ff_cmat", c_mat, {4{18'h1FC02}});
      tick();

      // Job 3: ALU never completes -> timeout after 8 WAIT cycles
      alu_en = 1'b0;
      launch(32'h04030201, 32'h08070605);
      wait_done(0, lat, nb, ns);
      chk("to_latency", 72'(lat), 72'(9));
      chk("to_starts", 72'(ns), 72'(1));
      chk("to_busy_cycles", 72'(nb), 72'(9));
      chk("to_err", 72'(err), 72'(1));
      chk("to_cmat_kept", c_mat, {4{18'h1FC02}});
      tick();
      chk("to_err_sticky", 72'(err), 72'(1));
      alu_en = 1'b1;

      // Job 4: identity x B, next go clears err
      launch(32'h01000001, 32'h08070605);
      chk("clr_err", 72'(err), 72'(0));
      wait_done(0, lat, nb, ns);
      chk("id_cmat", c_mat, cpack(5, 6, 7, 8));
      chk("id_err", 72'(err), 72'(0));
      tick();

      // Spurious complete in IDLE is ignored
      spur = 1'b1;
      tick();
      spur = 1'b0;
      tick();
      chk("spur_cmat", c_mat, cpack(5, 6, 7, 8));
      chk("spur_busy", 72'(busy), 72'(0));

      // Repeated go while busy is ignored
      launch(32'h04030201, 32'h08070605);
      a_mat = 32'hFFFFFFFF;
      b_mat = 32'hFFFFFFFF;
      go = 1'b1;
      repeat (5) tick();
      go = 1'b0;
      wait_done(5, lat, nb, ns);
      chk("rg_latency", 72'(lat), 72'(16));
      chk("rg_cmat", c_mat, cpack(19, 22, 43, 50));
      tick();
      chk("rg_no_second_done", 72'(done), 72'(0));
      chk("rg_idle", 72'(busy), 72'(0));

      // Reset during WAIT of element 2
      launch(32'h01000001, 32'h04030201);
      repeat (9) tick();
      chk("mid_busy", 72'(busy), 72'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 72'({busy, done, err, alu_start}), 72'(0));
      chk("mid_rst_cmat", c_mat, 72'(0));
      chk("mid_rst_ops", 72'(ops), 72'(0));
      seen = 1'b0;
      repeat (3) begin
         tick();
         seen = seen | done;
      end
      rst_n = 1'b1;
      tick();
      seen = seen | done;
      chk("mid_rst_no_done", 72'(seen), 72'(0));
      launch(32'h04030201, 32'h08070605);
      wait_done(0, lat, nb, ns);
      chk("post_rst_latency", 72'(lat), 72'(16));
      chk("post_rst_cmat", c_mat, cpack(19, 22, 43, 50));

      // go during the done cycle starts the next job immediately
      launch(32'h04030201, 32'h08070605);
      wait_done(0, lat, nb, ns);
      chk("b2b_first_done", 72'(done), 72'(1));
      a_mat = 32'h03000002;
      b_mat = 32'h04030201;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("b2b_accepted", 72'({busy, alu_start}), 72'(2'b11));
      chk("b2b_first_cmat", c_mat, cpack(19, 22, 43, 50));
      wait_done(0, lat, nb, ns);
      chk("b2b_latency", 72'(lat), 72'(16));
      chk("b2b_cmat", c_mat, cpack(2, 4, 9, 12));
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
